rom_state_machine: RTL

ROM_STATE_MACHINE -- requirements
Module: rom_state_machine

---
 rtl/rom_fsm_pkg.sv | 23 ++
 rtl/rom_fsm_mem.sv | 60 ++++++
 rtl/rom_state_machine.sv | 84 ++++++++
 3 files changed

// File: rtl/rom_fsm_pkg.sv
// rom_fsm_pkg: shared constants for the table-driven state machine.
//   DEF_S_W / DEF_X_W / DEF_Z_W : default state, input and output widths
//   MODE_MEALY / MODE_MOORE     : values for the MOORE parameter
//   DEF_TABLE                   : power-up contents of the default 8-entry table,
//                                 each word {next_state[1:0], out[0]}, address {state, x}
package rom_fsm_pkg;

    localparam int unsigned DEF_S_W = 2;
    localparam int unsigned DEF_X_W = 1;
    localparam int unsigned DEF_Z_W = 1;

    localparam int unsigned MODE_MEALY = 0;
    localparam int unsigned MODE_MOORE = 1;

    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_WORD_W = 3;

    localparam logic [DEF_WORD_W-1:0] DEF_TABLE [DEF_DEPTH] = '{
        3'b010, 3'b101, 3'b101, 3'b001,
        3'b001, 3'b010, 3'b000, 3'b000
    };

endpackage

// File: rtl/rom_fsm_mem.sv
// rom_fsm_mem: transition/output table with two asynchronous read ports and one
// synchronous write port. Contents power up to the package default table when the
// widths match the defaults, otherwise to all-zero.
//   clk_i      : write clock
//   we_i       : write strobe (caller gates it with reset)
//   waddr_i    : write address
//   wdata_i    : write word
//   raddr_a_i  : read address, port A (transition lookup)
//   rdata_a_o  : read word, port A
//   raddr_b_i  : read address, port B (Moore output lookup)
//   rdata_b_o  : read word, port B
module rom_fsm_mem
    import rom_fsm_pkg::*;
#(
    parameter int unsigned S_W = DEF_S_W,
    parameter int unsigned X_W = DEF_X_W,
    parameter int unsigned Z_W = DEF_Z_W
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [S_W+X_W-1:0]   waddr_i,
    input  logic [S_W+Z_W-1:0]   wdata_i,
    input  logic [S_W+X_W-1:0]   raddr_a_i,
    output logic [S_W+Z_W-1:0]   rdata_a_o,
    input  logic [S_W+X_W-1:0]   raddr_b_i,
    output logic [S_W+Z_W-1:0]   rdata_b_o
);

    localparam int unsigned A_W    = S_W + X_W;
    localparam int unsigned WORD_W = S_W + Z_W;
    localparam int unsigned DEPTH  = 1 << A_W;

    typedef logic [WORD_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        logic [2:0] idx;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = '0;
            if (S_W == DEF_S_W && X_W == DEF_X_W && Z_W == DEF_Z_W) begin
                idx  = 3'(i);
                m[i] = WORD_W'(DEF_TABLE[idx]);
            end
        end
        return m;
    endfunction

    // Declaration initialiser gives the power-up content; reset never touches it.
    logic [WORD_W-1:0] mem_q [DEPTH] = init_mem();

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/rom_state_machine.sv
// rom_state_machine: table-driven Mealy/Moore state machine with a writable table.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset of state and z (table untouched)
//   en         : step enable
//   x          : machine input
//   prog_we    : table write strobe; freezes state and z for that edge
//   prog_addr  : table write address {state, x}
//   prog_wdata : table write word {next_state, out}
//   state      : current state register
//   z          : registered machine output
module rom_state_machine
    import rom_fsm_pkg::*;
#(
    parameter int unsigned S_W   = DEF_S_W,
    parameter int unsigned X_W   = DEF_X_W,
    parameter int unsigned Z_W   = DEF_Z_W,
    parameter int unsigned MOORE = MODE_MEALY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [X_W-1:0]       x,
    input  logic                 prog_we,
    input  logic [S_W+X_W-1:0]   prog_addr,
    input  logic [S_W+Z_W-1:0]   prog_wdata,
    output logic [S_W-1:0]       state,
    output logic [Z_W-1:0]       z
);

    localparam int unsigned A_W    = S_W + X_W;
    localparam int unsigned WORD_W = S_W + Z_W;

    logic [S_W-1:0]    state_q, state_d;
    logic [Z_W-1:0]    z_q, z_d;
    logic [A_W-1:0]    trans_addr, moore_addr;
    logic [WORD_W-1:0] trans_word, moore_word;
    logic [S_W-1:0]    next_state;
    logic              mem_we;

    // Writes are suppressed while reset is asserted.
    assign mem_we = prog_we & rst_n;

    rom_fsm_mem #(
        .S_W (S_W),
        .X_W (X_W),
        .Z_W (Z_W)
    ) u_mem (
        .clk_i     (clk),
        .we_i      (mem_we),
        .waddr_i   (prog_addr),
        .wdata_i   (prog_wdata),
        .raddr_a_i (trans_addr),
        .rdata_a_o (trans_word),
        .raddr_b_i (moore_addr),
        .rdata_b_o (moore_word)
    );

    always_comb begin
        trans_addr = {state_q, x};
        next_state = trans_word[WORD_W-1:Z_W];
        // Moore output is the out field of the entered state's x=0 entry.
        moore_addr = {next_state, {X_W{1'b0}}};
        state_d    = state_q;
        z_d        = z_q;
        if (!prog_we && en) begin
            state_d = next_state;
            z_d     = (MOORE == MODE_MOORE) ? moore_word[Z_W-1:0] : trans_word[Z_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign state = state_q;
    assign z     = z_q;

endmodule
